// File: rtl/srl_dly_pkg.sv
// Shared types and helpers for the runtime-programmable SRL delay line.
// Holds the control FSM state encoding and the delay-code clamp.
package srl_dly_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Code k requests delay k+1; anything beyond the physical line saturates at its end.
  function automatic int depth_clamp(input int code, input int max_depth);
    return (code + 1 > max_depth) ? max_depth : code + 1;
  endfunction

endpackage

// File: rtl/srl_dly_line.sv
// Addressable shift storage: a data plane and a valid plane shifting together,
// with a synchronous clear of the valid plane only and a combinational tap.
module srl_dly_line
  import srl_dly_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_DEPTH = 32,
  parameter int AW        = $clog2(MAX_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic             i_clr_vld,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_valid,
  input  logic [AW-1:0]    i_addr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);

  logic [MAX_DEPTH-1:0][WIDTH-1:0] r_data;
  logic [MAX_DEPTH-1:0]            r_vld;

  // Data is only ever zeroed by reset; a clear drops the incoming valid bit too.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_vld  <= '0;
    end else if (i_ce) begin
      r_data <= {r_data[MAX_DEPTH-2:0], i_d};
      r_vld  <= i_clr_vld ? '0 : {r_vld[MAX_DEPTH-2:0], i_valid};
    end
  end

  assign o_q     = r_data[i_addr];
  assign o_valid = r_vld[i_addr];

endmodule

// File: rtl/srl_dly_ctrl.sv
// Runtime-programmable delay line with safe reconfiguration (request, flush, ack).
// Optional clock enable port ice is built in when SRL_DLY_CE_EN is defined.
module srl_dly_ctrl
  import srl_dly_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_DEPTH = 32,
  parameter int DEF_DEPTH = 5,
  parameter int AW        = $clog2(MAX_DEPTH)
) (
  input  logic             iclk,
  input  logic             irst_n,
`ifdef SRL_DLY_CE_EN
  input  logic             ice,
`endif
  input  logic [WIDTH-1:0] id,
  input  logic             ivalid,
  input  logic             icfg_req,
  input  logic [AW-1:0]    icfg_depth,
  output logic             ocfg_ack,
  output logic             obusy,
  output logic [WIDTH-1:0] oq,
  output logic             ovalid
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_dcode;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_new_code;
  logic          r_ack;
  logic          w_accept;
  logic          w_done;
  logic          w_ce;
  logic          w_tap_vld;

`ifdef SRL_DLY_CE_EN
  assign w_ce = ice;
`else
  assign w_ce = 1'b1;
`endif

  // Depth is kept as code (D-1) so it doubles as the tap address and the flush count.
  assign w_new_code = AW'(depth_clamp(int'(icfg_depth), MAX_DEPTH) - 1);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_ce && icfg_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_ce && (r_cnt == '0)) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_state <= ST_RUN;
      r_dcode <= AW'(DEF_DEPTH - 1);
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_done;
      if (w_accept) begin
        r_dcode <= w_new_code;
        r_cnt   <= w_new_code;
      end else if (w_ce && (r_state == ST_FLUSH) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  srl_dly_line #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .AW        (AW)
  ) u_line (
    .i_clk     (iclk),
    .i_rst_n   (irst_n),
    .i_ce      (w_ce),
    .i_clr_vld (w_accept),
    .i_d       (id),
    .i_valid   (ivalid),
    .i_addr    (r_dcode),
    .o_q       (oq),
    .o_valid   (w_tap_vld)
  );

  assign ovalid   = w_tap_vld & (r_state == ST_RUN);
  assign obusy    = (r_state == ST_FLUSH);
  assign ocfg_ack = r_ack;

endmodule
